// File: rtl/netwalk_dpl_pkg.sv
// NetWalk data-plane shared widths, opcodes, stage bundle and priority encoder.
// Imported by the TCAM and by netwalk_dataplane_core.
package netwalk_dpl_pkg;

    localparam int HDR_W   = 608;
    localparam int KEY_W   = 356;
    localparam int ACT_W   = 16;
    localparam int EXEC_W  = 372;
    localparam int TAG_W   = 5;
    localparam int KEY_LSB = 252;
    localparam int DEPTH   = 31;
    localparam int ADDR_W  = 6;

    localparam logic [TAG_W-1:0] TAG_MISS   = 5'd31;
    localparam logic [ACT_W-1:0] OP_DROP    = 16'h0000;
    localparam logic [ACT_W-1:0] OP_REWRITE = 16'h0001;

    typedef struct packed {
        logic             vld;
        logic             hit;
        logic [TAG_W-1:0] tag;
        logic [ACT_W-1:0] op;
        logic [HDR_W-1:0] hdr;
    } s1_t;

    // Lowest set index wins; no hit yields the miss tag.
    function automatic logic [TAG_W-1:0] prio_enc(input logic [DEPTH-1:0] hit);
        logic [TAG_W-1:0] tag;
        tag = TAG_MISS;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) tag = TAG_W'(i);
        end
        return tag;
    endfunction

endpackage

// File: rtl/netwalk_dataplane_core_tcam.sv
// Ternary key/mask/valid storage with program/delete and a
// combinational per-entry match vector.
module netwalk_tcam
    import netwalk_dpl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic             i_del,
    input  logic [TAG_W-1:0] i_idx,
    input  logic [KEY_W-1:0] i_data,
    input  logic [KEY_W-1:0] i_mask,
    input  logic [KEY_W-1:0] i_key,
    output logic [DEPTH-1:0] o_hit
);

    logic [KEY_W-1:0] r_data [DEPTH];
    logic [KEY_W-1:0] r_mask [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_del) begin
            r_valid[i_idx] <= 1'b0;
        end else if (i_wr) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Contents are qualified by r_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_data[i_idx] <= i_data & i_mask;
            r_mask[i_idx] <= i_mask;
        end
    end

    always_comb begin
        o_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_hit[i] = r_valid[i] &&
                       (((i_key ^ r_data[i]) & r_mask[i]) == '0);
        end
    end

endmodule

// File: rtl/netwalk_dataplane_core.sv
// NetWalk match-action core: TCAM lookup, action RAM, two-stage pipeline.
// Define NETWALK_REWRITE_EN to enable the key-region rewrite opcode.
module netwalk_dataplane_core
    import netwalk_dpl_pkg::*;
(
    input  logic              dpl_clk,
    input  logic              dpl_reset,
    input  logic [ADDR_W-1:0] dpl_program_addr,
    input  logic [KEY_W-1:0]  dpl_program_data,
    input  logic [KEY_W-1:0]  dpl_program_mask,
    input  logic [EXEC_W-1:0] dpl_exec_data,
    input  logic              dpl_program_enable,
    input  logic              dpl_delete_enable,
    input  logic [HDR_W-1:0]  dpl_pkt_header_in,
    input  logic              dpl_pkt_header_ready,
    output logic              dpl_pkt_header_accept,
    output logic [HDR_W-1:0]  dpl_pkt_header_out,
    output logic              dpl_pkt_header_out_enable,
    output logic [TAG_W-1:0]  dpl_flow_tag
);

    logic             w_addr_ok;
    logic             w_wr;
    logic             w_del;
    logic [TAG_W-1:0] w_idx;
    logic [DEPTH-1:0] w_hit;
    logic             w_any;
    logic [TAG_W-1:0] w_tag;
    logic [ACT_W-1:0] w_op;
    logic             w_drop;
    logic [HDR_W-1:0] w_hdr2;

    logic [ACT_W-1:0] r_op [DEPTH];
    s1_t              r_s1;
    logic [HDR_W-1:0] r_out;
    logic             r_out_en;
    logic [TAG_W-1:0] r_tag;

    assign w_addr_ok = dpl_program_addr < ADDR_W'(DEPTH);
    assign w_idx     = dpl_program_addr[TAG_W-1:0];
    assign w_del     = w_addr_ok && dpl_delete_enable;
    assign w_wr      = w_addr_ok && dpl_program_enable && !dpl_delete_enable;

    netwalk_tcam u_tcam (
        .clk    (dpl_clk),
        .rst_n  (dpl_reset),
        .i_wr   (w_wr),
        .i_del  (w_del),
        .i_idx  (w_idx),
        .i_data (dpl_program_data),
        .i_mask (dpl_program_mask),
        .i_key  (dpl_pkt_header_in[HDR_W-1:KEY_LSB]),
        .o_hit  (w_hit)
    );

    assign w_any = |w_hit;
    assign w_tag = prio_enc(w_hit);

    always_ff @(posedge dpl_clk) begin
        if (w_wr) r_op[w_idx] <= dpl_exec_data[EXEC_W-1:KEY_W];
    end

    always_comb begin
        w_op = OP_DROP;
        if (w_any) w_op = r_op[w_tag];
    end

`ifdef NETWALK_REWRITE_EN
    logic [KEY_W-1:0] r_rw [DEPTH];
    logic [KEY_W-1:0] w_rw;
    logic [KEY_W-1:0] r_s1_rw;

    always_ff @(posedge dpl_clk) begin
        if (w_wr) r_rw[w_idx] <= dpl_exec_data[KEY_W-1:0];
    end

    always_comb begin
        w_rw = '0;
        if (w_any) w_rw = r_rw[w_tag];
    end

    always_ff @(posedge dpl_clk or negedge dpl_reset) begin
        if (!dpl_reset) begin
            r_s1_rw <= '0;
        end else if (dpl_pkt_header_ready) begin
            r_s1_rw <= w_rw;
        end
    end
`else
    logic w_unused_rw;
    assign w_unused_rw = ^dpl_exec_data[KEY_W-1:0];
`endif

    // Action is captured with the match so a later table write cannot alter it.
    always_ff @(posedge dpl_clk or negedge dpl_reset) begin
        if (!dpl_reset) begin
            r_s1 <= '0;
        end else begin
            r_s1.vld <= dpl_pkt_header_ready;
            if (dpl_pkt_header_ready) begin
                r_s1.hit <= w_any;
                r_s1.tag <= w_tag;
                r_s1.op  <= w_op;
                r_s1.hdr <= dpl_pkt_header_in;
            end
        end
    end

    assign w_drop = r_s1.hit && (r_s1.op == OP_DROP);

    always_comb begin
        w_hdr2 = r_s1.hdr;
`ifdef NETWALK_REWRITE_EN
        if (r_s1.hit && (r_s1.op == OP_REWRITE)) begin
            w_hdr2 = {r_s1_rw, r_s1.hdr[KEY_LSB-1:0]};
        end
`endif
    end

    always_ff @(posedge dpl_clk or negedge dpl_reset) begin
        if (!dpl_reset) begin
            r_out    <= '0;
            r_out_en <= 1'b0;
            r_tag    <= '0;
        end else begin
            r_out_en <= r_s1.vld && !w_drop;
            if (r_s1.vld && !w_drop) begin
                r_out <= w_hdr2;
                r_tag <= r_s1.tag;
            end
        end
    end

    assign dpl_pkt_header_accept     = dpl_reset;
    assign dpl_pkt_header_out        = r_out;
    assign dpl_pkt_header_out_enable = r_out_en;
    assign dpl_flow_tag              = r_tag;

endmodule

// File: tb/tb_netwalk_dataplane_core.sv
// Scoreboard bench for netwalk_dataplane_core: directed packets, queued
// expectations, independent output monitor.
module tb_netwalk_dataplane_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   paddr = '0;
    logic [355:0] pdata = '0;
    logic [355:0] pmask = '0;
    logic [371:0] pexec = '0;
    logic         pen = 1'b0;
    logic         den = 1'b0;
    logic [607:0] hin = '0;
    logic         hrdy = 1'b0;
    logic         accept;
    logic [607:0] hout;
    logic         out_en;
    logic [4:0]   tag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [607:0] hdr;
        logic [4:0]   tag;
    } exp_t;
    exp_t sbq[$];

    netwalk_dataplane_core dut (
        .dpl_clk                   (clk),
        .dpl_reset                 (rst_n),
        .dpl_program_addr          (paddr),
        .dpl_program_data          (pdata),
        .dpl_program_mask          (pmask),
        .dpl_exec_data             (pexec),
        .dpl_program_enable        (pen),
        .dpl_delete_enable         (den),
        .dpl_pkt_header_in         (hin),
        .dpl_pkt_header_ready      (hrdy),
        .dpl_pkt_header_accept     (accept),
        .dpl_pkt_header_out        (hout),
        .dpl_pkt_header_out_enable (out_en),
        .dpl_flow_tag              (tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    function automatic logic [355:0] mk(input logic [31:0] s);
        return {s, {10{s ^ 32'hA5A5_0F0F}}, 4'h9};
    endfunction

    function automatic logic [607:0] mkh(input logic [355:0] k,
                                         input logic [35:0] s);
        return {k, {7{s}}};
    endfunction

    task automatic chk_w(input string nm, input logic [607:0] act,
                         input logic [607:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_n(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_en !== 1'b0) begin
            if (sbq.size() == 0) begin
                chk_n("unexpected_out", 32'(out_en), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk_w("hdr_out", hout, e.hdr);
                chk_n("flow_tag", 32'(tag), 32'(e.tag));
            end
        end
    end

    task automatic send(input logic [607:0] h, input bit exp,
                        input logic [4:0] t, input logic [607:0] eh);
        exp_t x;
        hin  = h;
        hrdy = 1'b1;
        if (exp) begin
            x.hdr = eh;
            x.tag = t;
            sbq.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        hrdy = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic prog(input logic [5:0] a, input logic [355:0] d,
                        input logic [355:0] m, input logic [15:0] op,
                        input logic [355:0] rw, input logic p,
                        input logic dl);
        paddr = a;
        pdata = d;
        pmask = m;
        pexec = {op, rw};
        pen   = p;
        den   = dl;
        @(negedge clk);
        pen = 1'b0;
        den = 1'b0;
    endtask

    logic [355:0] ones, m4, k1, k3, k5, k6, k7, k40, km, rw3;
    logic [607:0] p1, p1b, p3, e3, p5, p6, p7, p40, pm;

    initial begin
        ones = '1;
        m4   = {32'hFFFF_FFFF, 324'b0};
        k1   = mk(32'h1111_0001);
        k3   = mk(32'h3333_0003);
        k5   = mk(32'h5555_0005);
        k6   = mk(32'h6666_0006);
        k7   = mk(32'h7777_0707);
        k40  = mk(32'h4040_0040);
        km   = mk(32'h7777_0007);
        rw3  = mk(32'hDEAD_BEEF);
        p1   = mkh(k1, 36'h0_1111_1111);
        p1b  = mkh(k1 ^ 356'h1, 36'h0_2222_2222);
        p3   = mkh(k3, 36'h1_2345_6789);
        p5   = mkh(k5, 36'h5_5555_5555);
        p6   = mkh(k6, 36'h6_6666_6666);
        p7   = mkh(k7, 36'h7_0707_0707);
        p40  = mkh(k40, 36'h4_0404_0404);
        pm   = mkh(km, 36'hA_BCDE_F012);
`ifdef NETWALK_REWRITE_EN
        e3 = {rw3, p3[251:0]};
`else
        e3 = p3;
`endif

        repeat (3) @(negedge clk);
        chk_w("rst_hdr_out", hout, 608'd0);
        chk_n("rst_out_en", 32'(out_en), 32'd0);
        chk_n("rst_tag", 32'(tag), 32'd0);
        chk_n("rst_accept", 32'(accept), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_n("accept", 32'(accept), 32'd1);
        idle(3);

        prog(6'd3, k3, ones, 16'h0001, rw3, 1'b1, 1'b0);
        send(p3, 1'b1, 5'd3, e3);
        idle(3);
        send(pm, 1'b1, 5'd31, pm);
        idle(3);

        prog(6'd1, k1, ones, 16'h0002, '0, 1'b1, 1'b0);
        prog(6'd4, k1 ^ {32'h0, {324{1'b1}}}, m4, 16'h0005, '0,
             1'b1, 1'b0);
        send(p1, 1'b1, 5'd1, p1);
        send(p1b, 1'b1, 5'd4, p1b);
        idle(1);
        prog(6'd1, '0, '0, 16'h0000, '0, 1'b0, 1'b1);
        send(p1, 1'b1, 5'd4, p1);
        idle(3);

        prog(6'd6, k6, ones, 16'h0000, '0, 1'b1, 1'b0);
        send(pm, 1'b1, 5'd31, pm);
        send(p6, 1'b0, 5'd0, '0);
        send(p3, 1'b1, 5'd3, e3);
        send(p3, 1'b1, 5'd3, e3);
        idle(4);

        paddr = 6'd5;
        pdata = k5;
        pmask = ones;
        pexec = {16'h0003, 356'd0};
        pen   = 1'b1;
        send(p5, 1'b1, 5'd31, p5);
        pen = 1'b0;
        send(p5, 1'b1, 5'd5, p5);
        idle(3);

        prog(6'd40, k40, ones, 16'h0002, '0, 1'b1, 1'b0);
        send(p40, 1'b1, 5'd31, p40);
        idle(3);
        prog(6'd7, k7, ones, 16'h0002, '0, 1'b1, 1'b1);
        send(p7, 1'b1, 5'd31, p7);
        idle(3);

        send(p3, 1'b0, 5'd0, '0);
        hrdy  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_n("midrst_out_en", 32'(out_en), 32'd0);
        chk_n("midrst_tag", 32'(tag), 32'd0);
        rst_n = 1'b1;
        idle(4);
        send(p3, 1'b1, 5'd31, p3);
        idle(4);

        chk_n("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/netwalk_dataplane_core.md
# netwalk_dataplane_core

Single-clock match-action core for the NetWalk data plane. It holds a 31-entry ternary flow table, programmed by the control plane, with a per-entry action word. Every accepted 608-bit packet header is classified by this table, then dropped, forwarded unchanged, or forwarded with a rewritten key region. Classified headers are emitted with a 5-bit flow tag to the downstream egress logic.

## Interface
- DEPTH, 31: usable table entries (indices 0..30); tag 31 is reserved for "miss".
- dpl_clk  in  1  sole clock; all state changes on its rising edge.
- dpl_reset  in  1  reset, asynchronous, active-low.
- dpl_program_addr  in  6  entry index for program/delete; values >= 31 are ignored.
- dpl_program_data  in  356  key value for the entry.
- dpl_program_mask  in  356  care mask; bit=1 means compare, bit=0 means don't-care.
- dpl_exec_data  in  372  action word: [371:356] opcode, [355:0] rewrite value.
- dpl_program_enable  in  1  write data/mask/exec into the entry and set it valid.
- dpl_delete_enable  in  1  clear the entry's valid bit.
- dpl_pkt_header_in  in  608  packet header; key = [607:252].
- dpl_pkt_header_ready  in  1  header valid this cycle.
- dpl_pkt_header_accept  out  1  core can take a header.
- dpl_pkt_header_out  out  608  processed header.
- dpl_pkt_header_out_enable  out  1  one-cycle strobe qualifying out/tag.
- dpl_flow_tag  out  5  matched entry index, or 31 on miss.

## Operation
- Programming (any cycle, independent of traffic):
  - Stored data = program_data & program_mask.
  - Valid is set on program_enable.
  - If delete_enable and program_enable are high together, delete wins.
- Match for entry i: valid[i] and ((key ^ data[i]) & mask[i]) == 0. The lowest matching index wins.
- Opcodes:
  - 0x0000: drop. No out_enable.
  - 0x0001: rewrite. Output = {exec[355:0], header_in[251:0]}.
  - Any other value: forward unchanged.
- Miss: forward unchanged with flow_tag = 31.
- dpl_pkt_header_accept = 1 whenever out of reset. The core is fully pipelined with no backpressure; ready is a pure valid.
- A header present with ready high on consecutive edges is processed each cycle. A held header therefore produces repeated outputs.
- Reset values: all valid bits 0, pipeline valids 0, header_out 0, out_enable 0, flow_tag 0, accept 0 during reset.

## Timing
- Two-stage pipeline.
  - Edge N: capture the header and the match vector, computed combinationally from the table contents before edge N.
  - Edge N+1: register header_out, flow_tag and out_enable.
  - Result: a header sampled at edge N is visible after edge N+1, i.e. latency 2 edges.
- Write/lookup hazard: a table write at edge N affects lookups sampled from edge N+1 on. A lookup at the same edge sees old contents.
- Throughput is 1 header per cycle. Dropped packets leave a bubble (out_enable 0).
- Reset asserted mid-operation: in-flight headers are discarded immediately and the table is cleared. No output follows release until new headers arrive.

## Configuration
- NETWALK_REWRITE_EN defined: opcode 0x0001 rewrites as above.
- NETWALK_REWRITE_EN undefined:
  - Opcode 0x0001 forwards unchanged.
  - exec[355:0] need not be stored, so that storage is removed.
  - Tag and drop behaviour are unchanged.

## Structure
- Package netwalk_dpl_pkg holds:
  - Widths: HDR_W=608, KEY_W=356, ACT_W=16, EXEC_W=372, TAG_W=5.
  - Key offset KEY_LSB=252, TAG_MISS=31.
  - Opcode constants OP_DROP=16'h0000, OP_REWRITE=16'h0001.
- One sub-module, netwalk_tcam: data/mask/valid storage, program/delete, and the combinational match vector. The wrapper owns the action RAM, priority encoder and pipeline.

## Test plan
- Reset, then idle: all outputs 0 during reset; accept=1 after release; out_enable stays 0 with ready=0.
- Program entry 3 with exact mask (all ones) and opcode 0x0001, then send a header whose [607:252] equals the data. After 2 edges: out_enable=1, flow_tag=3, header_out[607:252] = exec[355:0], low 252 bits unchanged.
- Header matching no entry: tag=31, header_out == header_in.
- Entries 1 and 4 both match (entry 4 with a partial mask): tag=1. After deleting entry 1: tag=4.
- Opcode 0x0000 entry matched: no out_enable for that packet; the neighbouring back-to-back packets still emerge in order.
- Program entry 5 in the same cycle as a matching lookup: that packet misses (tag 31); the next identical packet hits (tag 5). An addr=40 write has no effect.
